insertion_sort_engine: RTL

Self-contained in-place insertion sorter: FSM and datapath in one block. It sorts an array of `arr_size` words held in an external memory, reached over a valid/ready read/write channel set. It adds runtime array size, ascending/descending order, signed/unsigned compare, response checking, and a skip of redundant key write-backs. It sits between the user start/done interface and the memory model/arbiter.

---
 rtl/insertion_sort_engine.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/insertion_sort_engine.sv
// In-place insertion sorter driving a valid/ready read/write memory channel set.
// One transaction is in flight at a time. The key write-back is skipped when no element moved.
module insertion_sort_engine #(
    parameter int unsigned ADDR_WDTH = 4,
    parameter int unsigned DATA_WDTH = 32,
    parameter int unsigned RESP_WDTH = 1,
    parameter bit          SIGNED    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_WDTH:0]   arr_size,
    input  logic                 descending,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 ar_valid,
    input  logic                 ar_ready,
    output logic [ADDR_WDTH-1:0] ar_addr,
    input  logic                 r_valid,
    output logic                 r_ready,
    input  logic [DATA_WDTH-1:0] r_data,
    input  logic [RESP_WDTH-1:0] r_resp,
    output logic                 aw_valid,
    input  logic                 aw_ready,
    output logic [ADDR_WDTH-1:0] aw_addr,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [DATA_WDTH-1:0] w_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [RESP_WDTH-1:0] b_resp
);

    localparam int unsigned   CW      = ADDR_WDTH + 1;
    localparam logic [CW-1:0] One     = {{ADDR_WDTH{1'b0}}, 1'b1};
    localparam logic [CW-1:0] MaxSize = {1'b1, {ADDR_WDTH{1'b0}}};

    typedef enum logic [3:0] {
        StIdle, StKeyAr, StKeyR, StCmpAr, StCmpR, StEval, StShW,
        StShB, StInsW, StInsB, StNext, StDone, StErr
    } state_e;

    state_e state_q, state_d;

    // j is a two's-complement index so that j = -1 shows up as the MSB being set.
    logic [CW-1:0]        i_q, i_d, j_q, j_d, size_q, size_d;
    logic [DATA_WDTH-1:0] key_q, key_d, cmp_q, cmp_d;
    logic                 desc_q, desc_d, shifted_q, shifted_d, error_q, error_d;
    logic                 aw_done_q, aw_done_d, w_done_q, w_done_d;

    logic [CW-1:0] size_clamped, i_inc, j_inc;
    logic          ar_hs, r_hs, aw_hs, w_hs, b_hs, r_err, b_err;
    logic          aw_acc, w_acc, both_acc, cmp_gt, cmp_lt, after;

    assign size_clamped = (arr_size > MaxSize) ? MaxSize : arr_size;
    assign i_inc        = i_q + One;
    assign j_inc        = j_q + One;

    assign ar_hs    = ar_valid & ar_ready;
    assign r_hs     = r_valid & r_ready;
    assign aw_hs    = aw_valid & aw_ready;
    assign w_hs     = w_valid & w_ready;
    assign b_hs     = b_valid & b_ready;
    assign r_err    = |r_resp;
    assign b_err    = |b_resp;
    assign aw_acc   = aw_done_q | aw_hs;
    assign w_acc    = w_done_q | w_hs;
    assign both_acc = aw_acc & w_acc;

    always_comb begin
        if (SIGNED) begin
            cmp_gt = $signed(cmp_q) > $signed(key_q);
            cmp_lt = $signed(cmp_q) < $signed(key_q);
        end else begin
            cmp_gt = cmp_q > key_q;
            cmp_lt = cmp_q < key_q;
        end
        after = desc_q ? cmp_lt : cmp_gt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = (size_clamped <= One) ? StDone : StKeyAr;
            StKeyAr: if (ar_hs) state_d = StKeyR;
            StKeyR:  if (r_hs) state_d = r_err ? StErr : StCmpAr;
            StCmpAr: if (ar_hs) state_d = StCmpR;
            StCmpR:  if (r_hs) state_d = r_err ? StErr : StEval;
            StEval:  state_d = after ? StShW : (shifted_q ? StInsW : StNext);
            StShW:   if (both_acc) state_d = StShB;
            StShB: begin
                if (b_hs) begin
                    if (b_err)          state_d = StErr;
                    else if (j_q == '0) state_d = StInsW;
                    else                state_d = StCmpAr;
                end
            end
            StInsW:  if (both_acc) state_d = StInsB;
            StInsB:  if (b_hs) state_d = b_err ? StErr : StNext;
            StNext:  state_d = (i_inc == size_q) ? StDone : StKeyAr;
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        i_d       = i_q;
        j_d       = j_q;
        size_d    = size_q;
        key_d     = key_q;
        cmp_d     = cmp_q;
        desc_d    = desc_q;
        shifted_d = shifted_q;
        error_d   = error_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    size_d  = size_clamped;
                    desc_d  = descending;
                    i_d     = One;
                    error_d = 1'b0;
                end
            end
            StKeyR: begin
                if (r_hs && !r_err) begin
                    key_d     = r_data;
                    j_d       = i_q - One;
                    shifted_d = 1'b0;
                end
            end
            StCmpR:  if (r_hs && !r_err) cmp_d = r_data;
            StShW, StInsW: begin
                aw_done_d = aw_acc & ~both_acc;
                w_done_d  = w_acc & ~both_acc;
            end
            StShB: begin
                if (b_hs && !b_err) begin
                    shifted_d = 1'b1;
                    j_d       = j_q - One;
                end
            end
            StNext:  i_d = i_inc;
            default: ;
        endcase
        if (state_d == StErr) error_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q       <= '0;
            j_q       <= '0;
            size_q    <= '0;
            key_q     <= '0;
            cmp_q     <= '0;
            desc_q    <= 1'b0;
            shifted_q <= 1'b0;
            error_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            i_q       <= i_d;
            j_q       <= j_d;
            size_q    <= size_d;
            key_q     <= key_d;
            cmp_q     <= cmp_d;
            desc_q    <= desc_d;
            shifted_q <= shifted_d;
            error_q   <= error_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        busy     = (state_q != StIdle);
        done     = (state_q == StDone) || (state_q == StErr);
        error    = error_q;
        ar_valid = (state_q == StKeyAr) || (state_q == StCmpAr);
        ar_addr  = '0;
        if (state_q == StKeyAr)      ar_addr = i_q[ADDR_WDTH-1:0];
        else if (state_q == StCmpAr) ar_addr = j_q[ADDR_WDTH-1:0];
        r_ready  = (state_q == StKeyR) || (state_q == StCmpR);
        aw_valid = ((state_q == StShW) || (state_q == StInsW)) && !aw_done_q;
        w_valid  = ((state_q == StShW) || (state_q == StInsW)) && !w_done_q;
        aw_addr  = ((state_q == StShW) || (state_q == StInsW)) ? j_inc[ADDR_WDTH-1:0] : '0;
        w_data   = '0;
        if (state_q == StShW)       w_data = cmp_q;
        else if (state_q == StInsW) w_data = key_q;
        b_ready  = (state_q == StShB) || (state_q == StInsB);
    end

endmodule
